// File: rtl/branch_predict_fetch.sv
// Fetch PC generator with a direct-mapped BTB and 2-bit saturating counters.
// Resolves branches from execute, redirects on mispredict and trains the table.
module branch_predict_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IDX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    input  logic        ResolveValidE,
    input  logic [31:0] PCE,
    input  logic [1:0]  PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] ALUResultE,
    input  logic        PredTakenE,
    input  logic [31:0] PredTargetE,
    output logic        MispredictE,
    output logic [31:0] MispredCount
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 30 - IDX_BITS;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];

    logic [IDX_BITS-1:0] f_idx, e_idx;
    logic [TAG_W-1:0]    f_tag, e_tag;
    logic                f_hit, e_hit;
    logic                act_taken;
    logic [31:0]         act_target, redirect, pc_next;

    // Fetch-side lookup always sees the pre-update table contents.
    assign f_idx       = PCF[IDX_BITS+1:2];
    assign f_tag       = PCF[31:IDX_BITS+2];
    assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign PCPlus4F    = PCF + 32'd4;
    assign PredTakenF  = f_hit && ctr_q[f_idx][1];
    assign PredTargetF = f_hit ? tgt_q[f_idx] : 32'd0;

    assign e_idx       = PCE[IDX_BITS+1:2];
    assign e_tag       = PCE[31:IDX_BITS+2];
    assign e_hit       = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    assign act_taken   = ResolveValidE && ((PCSrcE == 2'b01) || (PCSrcE == 2'b10));
    assign act_target  = (PCSrcE == 2'b10) ? (ALUResultE & ~32'd1) : PCTargetE;
    assign MispredictE = ResolveValidE &&
                         ((act_taken != PredTakenE) || (act_taken && (act_target != PredTargetE)));
    assign redirect    = act_taken ? act_target : PCE + 32'd4;

    always_comb begin
        pc_next = PCPlus4F;
        if (MispredictE)
            pc_next = redirect;
        else if (StallF)
            pc_next = PCF;
        else if (PredTakenF)
            pc_next = PredTargetF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PCF          <= RESET_PC;
            MispredCount <= 32'd0;
        end else begin
            PCF <= pc_next;
            if (MispredictE)
                MispredCount <= MispredCount + 32'd1;
        end
    end

    // Training ignores stalls and mispredicts: every resolved control op updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= 2'b01;
            end
        end else if (ResolveValidE) begin
            if (act_taken) begin
                if (e_hit) begin
                    tgt_q[e_idx] <= act_target;
                    if (ctr_q[e_idx] != 2'b11)
                        ctr_q[e_idx] <= ctr_q[e_idx] + 2'b01;
                end else begin
                    valid_q[e_idx] <= 1'b1;
                    tag_q[e_idx]   <= e_tag;
                    tgt_q[e_idx]   <= act_target;
                    ctr_q[e_idx]   <= 2'b10;
                end
            end else if (e_hit && (ctr_q[e_idx] != 2'b00)) begin
                ctr_q[e_idx] <= ctr_q[e_idx] - 2'b01;
            end
        end
    end
endmodule

// File: tb/tb_branch_predict_fetch.sv
// Scoreboard bench for branch_predict_fetch: a reference predictor pushes the
// expected next PC / mispredict count each cycle, popped after the clock edge.
module tb_branch_predict_fetch;
    logic        clk, rst, StallF;
    logic [31:0] PCF, PCPlus4F, PredTargetF;
    logic        PredTakenF;
    logic        ResolveValidE, PredTakenE, MispredictE;
    logic [31:0] PCE, PCTargetE, ALUResultE, PredTargetE, MispredCount;
    logic [1:0]  PCSrcE;

    branch_predict_fetch #(.RESET_PC(32'h0), .IDX_BITS(4)) dut (
        .clk(clk), .rst(rst), .StallF(StallF),
        .PCF(PCF), .PCPlus4F(PCPlus4F), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
        .ResolveValidE(ResolveValidE), .PCE(PCE), .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE), .ALUResultE(ALUResultE),
        .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
        .MispredictE(MispredictE), .MispredCount(MispredCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cnt;
    } exp_t;
    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    // reference state: 16-entry table, tag = pc[31:6]
    logic [31:0] m_pc, m_cnt;
    logic        m_val [16];
    logic [25:0] m_tag [16];
    logic [31:0] m_tgt [16];
    logic [1:0]  m_ctr [16];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc  = 32'h0;
        m_cnt = 32'h0;
        for (int i = 0; i < 16; i++) begin
            m_val[i] = 1'b0;
            m_tag[i] = '0;
            m_tgt[i] = '0;
            m_ctr[i] = 2'b01;
        end
        sb.delete();
    endtask

    task automatic cyc(input logic st, input logic rv, input logic [31:0] pce,
                       input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu,
                       input logic pte, input logic [31:0] ptgt);
        exp_t        e;
        logic [3:0]  fi, ei;
        logic        fh, eh, mpt, at, mis;
        logic [31:0] mpg, atg, rd;
        StallF = st; ResolveValidE = rv; PCE = pce; PCSrcE = src;
        PCTargetE = tgt; ALUResultE = alu; PredTakenE = pte; PredTargetE = ptgt;
        #1;
        fi  = m_pc[5:2];
        fh  = m_val[fi] && (m_tag[fi] == m_pc[31:6]);
        mpt = fh && m_ctr[fi][1];
        mpg = fh ? m_tgt[fi] : 32'h0;
        at  = rv && (src == 2'b01 || src == 2'b10);
        atg = (src == 2'b10) ? {alu[31:1], 1'b0} : tgt;
        mis = rv && ((at != pte) || (at && atg != ptgt));
        rd  = at ? atg : pce + 32'd4;
        chk("pcf", PCF, m_pc);
        chk("pcplus4", PCPlus4F, m_pc + 32'd4);
        chk("predtaken", 32'(PredTakenF), 32'(mpt));
        chk("predtarget", PredTargetF, mpg);
        chk("mispredict", 32'(MispredictE), 32'(mis));
        e.pc  = mis ? rd : st ? m_pc : mpt ? mpg : m_pc + 32'd4;
        e.cnt = m_cnt + 32'(mis);
        sb.push_back(e);
        ei = pce[5:2];
        eh = m_val[ei] && (m_tag[ei] == pce[31:6]);
        if (at) begin
            if (eh) begin
                m_tgt[ei] = atg;
                if (m_ctr[ei] != 2'b11) m_ctr[ei] = m_ctr[ei] + 2'b01;
            end else begin
                m_val[ei] = 1'b1; m_tag[ei] = pce[31:6]; m_tgt[ei] = atg; m_ctr[ei] = 2'b10;
            end
        end else if (rv && eh && m_ctr[ei] != 2'b00) begin
            m_ctr[ei] = m_ctr[ei] - 2'b01;
        end
        @(posedge clk); #1;
        e = sb.pop_front();
        chk("pcf_next", PCF, e.pc);
        chk("mispred_count", MispredCount, e.cnt);
        m_pc = e.pc; m_cnt = e.cnt;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    // force fetch to pc via a not-taken mispredict of the (untrained) pc-4 slot
    task automatic goto(input logic [31:0] pc);
        cyc(1'b0, 1'b1, pc - 32'd4, 2'b00, 32'h0, 32'h0, 1'b1, 32'h0);
        chk("goto_pcf", PCF, pc);
    endtask

    task automatic resolve(input logic [31:0] pce, input logic [1:0] src, input logic [31:0] tgt,
                           input logic pte, input logic [31:0] ptgt);
        cyc(1'b0, 1'b1, pce, src, tgt, 32'h0, pte, ptgt);
    endtask

    initial begin
        logic [31:0] pcs [6];
        pcs[0] = 32'h10; pcs[1] = 32'h14; pcs[2] = 32'h50;
        pcs[3] = 32'h20; pcs[4] = 32'h60; pcs[5] = 32'h100;
        rst = 1'b1; StallF = 1'b0; ResolveValidE = 1'b0; PCE = '0; PCSrcE = '0;
        PCTargetE = '0; ALUResultE = '0; PredTakenE = 1'b0; PredTargetE = '0;
        model_reset();
        #12;
        chk("rst_pcf", PCF, 32'h0);
        chk("rst_predtaken", 32'(PredTakenF), 32'h0);
        chk("rst_predtarget", PredTargetF, 32'h0);
        chk("rst_mispredict", 32'(MispredictE), 32'h0);
        chk("rst_count", MispredCount, 32'h0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 4; i++) idle();
        chk("seq_pcf", PCF, 32'h10);

        // first taken resolve of 0x10 allocates with ctr=10
        resolve(32'h10, 2'b01, 32'h40, 1'b0, 32'h0);
        chk("redir_pcf", PCF, 32'h40);
        chk("redir_count", MispredCount, 32'd1);
        goto(32'h10);
        chk("alloc_predtaken", 32'(PredTakenF), 32'd1);
        chk("alloc_predtarget", PredTargetF, 32'h40);
        idle();
        chk("follow_pred", PCF, 32'h40);

        // counter walk 10 -> 11 -> 11 -> 10 -> 01 -> 00 -> 00
        resolve(32'h10, 2'b01, 32'h40, 1'b1, 32'h40);
        resolve(32'h10, 2'b01, 32'h40, 1'b1, 32'h40);
        resolve(32'h10, 2'b00, 32'h0, 1'b1, 32'h40);
        chk("nt_redirect", PCF, 32'h14);
        goto(32'h10);
        chk("ctr10_predtaken", 32'(PredTakenF), 32'd1);
        resolve(32'h10, 2'b00, 32'h0, 1'b0, 32'h0);
        goto(32'h10);
        chk("ctr01_predtaken", 32'(PredTakenF), 32'd0);
        resolve(32'h10, 2'b00, 32'h0, 1'b0, 32'h0);
        resolve(32'h10, 2'b00, 32'h0, 1'b0, 32'h0);
        goto(32'h10);
        chk("ctr00_predtaken", 32'(PredTakenF), 32'd0);
        chk("ctr00_predtarget", PredTargetF, 32'h40);

        // jalr with odd target
        resolve(32'h20, 2'b01, 32'h1230, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 32'h20, 2'b10, 32'h0, 32'h1235, 1'b1, 32'h1230);
        chk("jalr_pcf", PCF, 32'h1234);
        goto(32'h20);
        chk("jalr_btb_target", PredTargetF, 32'h1234);

        // mispredict overrides stall, then a pure stall holds
        cyc(1'b1, 1'b1, 32'h60, 2'b01, 32'h80, 32'h0, 1'b0, 32'h0);
        chk("stall_redirect", PCF, 32'h80);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
            chk("stall_hold", PCF, 32'h80);
        end

        // tag alias 0x50 evicts 0x10
        resolve(32'h10, 2'b01, 32'h40, 1'b0, 32'h0);
        resolve(32'h50, 2'b01, 32'h90, 1'b0, 32'h0);
        goto(32'h10);
        chk("alias_predtaken", 32'(PredTakenF), 32'd0);
        chk("alias_predtarget", PredTargetF, 32'h0);
        goto(32'h50);
        chk("alias_new_target", PredTargetF, 32'h90);

        // PC wraps modulo 2^32
        goto(32'hFFFF_FFFC);
        idle();
        chk("pc_wrap", PCF, 32'h0);

        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 3) == 0), 1'($urandom), pcs[$urandom_range(0, 5)],
                2'($urandom), {24'h0, 6'($urandom), 2'b00}, $urandom,
                1'($urandom), {24'h0, 6'($urandom), 2'b00});
        end

        // asynchronous reset mid-run
        resolve(32'h10, 2'b01, 32'h40, 1'b0, 32'h0);
        StallF = 1'b0; ResolveValidE = 1'b0; rst = 1'b1;
        #1;
        chk("midrst_pcf", PCF, 32'h0);
        chk("midrst_count", MispredCount, 32'h0);
        chk("midrst_predtaken", 32'(PredTakenF), 32'd0);
        chk("midrst_mispredict", 32'(MispredictE), 32'd0);
        model_reset();
        @(negedge clk); rst = 1'b0;
        idle();
        goto(32'h10);
        chk("midrst_miss", 32'(PredTakenF), 32'd0);
        for (int i = 0; i < 3; i++) idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/branch_predict_fetch.md
Name: branch_predict_fetch

Overview:
- Fetch-side PC generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating counters.
- The predictor sits at the other end of the execute stage's branch-resolution interface. It issues predicted PCs into fetch.
- Each cycle it consumes PCSrcE/PCTargetE/ALUResultE from execute, detects mispredictions, redirects the PC and trains the table.
- Its outputs drive instruction-memory addressing and the hazard unit's flush logic.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- IDX_BITS, 4, log2 of BTB entries (16 entries default); tag = PC[31:IDX_BITS+2].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- StallF  in  1  hazard unit: hold PCF this cycle.
- PCF  out  32  current fetch PC.
- PCPlus4F  out  32  PCF+4.
- PredTakenF  out  1  prediction for PCF (carried down the pipeline).
- PredTargetF  out  32  predicted target for PCF (valid when PredTakenF).
- ResolveValidE  in  1  execute holds a valid control-flow instruction (branch/jal/jalr).
- PCE  in  32  PC of the instruction in execute.
- PCSrcE  in  2  execute resolution: 00 not taken, 01 taken to PCTargetE, 10 taken to ALUResultE (jalr), 11 treated as 00.
- PCTargetE  in  32  PC+imm target from execute.
- ALUResultE  in  32  jalr target from execute (bit 0 cleared internally).
- PredTakenE  in  1  prediction originally made for PCE.
- PredTargetE  in  32  predicted target originally made for PCE.
- MispredictE  out  1  combinational flush request to the hazard unit (flush D and E).
- MispredCount  out  32  count of mispredictions, wraps at 2^32.

Behaviour:
- Reset (async, immediate):
  - PCF = RESET_PC.
  - All BTB valid bits = 0, all counters = 2'b01, MispredCount = 0.
  - Outputs: PredTakenF = 0, PredTargetF = 0 (forced while the table is empty), MispredictE = 0 while ResolveValidE = 0.
- Lookup (combinational on PCF):
  - idx = PCF[IDX_BITS+1:2].
  - hit = valid[idx] && tag[idx] == PCF[31:IDX_BITS+2].
  - PredTakenF = hit && ctr[idx][1].
  - PredTargetF = hit ? target[idx] : 0.
- Resolution (combinational):
  - actTaken = ResolveValidE && PCSrcE ∈ {01,10}.
  - actTarget = PCSrcE==10 ? {ALUResultE[31:1],1'b0} : PCTargetE.
  - MispredictE = ResolveValidE && (actTaken != PredTakenE || (actTaken && actTarget != PredTargetE)).
  - redirect = actTaken ? actTarget : PCE+4.
- Next-PC priority, registered on the rising edge:
  1. MispredictE → redirect (overrides StallF).
  2. StallF → hold.
  3. PredTakenF → PredTargetF.
  4. Otherwise PCF+4.
- Latency: one redirected cycle after a mispredict; a correct prediction costs no bubbles.
- BTB update, on the edge when ResolveValidE=1, index/tag taken from PCE:
  - Taken, hit: target ← actTarget; ctr saturating +1 (max 11).
  - Taken, miss (including tag alias): allocate or overwrite; valid ← 1, tag, target ← actTarget, ctr ← 2'b10.
  - Not taken, hit: ctr saturating −1 (min 00); entry stays valid.
  - Not taken, miss: no change.
  - Update is independent of MispredictE and of StallF.
- Same-cycle lookup and update to the same index: lookup sees the pre-update contents; the new contents are visible the next cycle.
- MispredCount increments by 1 on each edge with MispredictE=1; it wraps from FFFF_FFFF to 0.
- Arithmetic: all PC math is 32-bit modulo 2^32 (PC+4 at FFFF_FFFC gives 0).
- Reset mid-operation: any pending redirect is discarded; the table is cleared; PCF is RESET_PC on the first edge after rst deasserts.

Test Plan:
- Reset, no stalls, ResolveValidE=0 → PCF goes 0,4,8,C; PredTakenF=0 throughout; MispredictE=0.
- Resolve PCE=0x10, PCSrcE=01, PCTargetE=0x40, PredTakenE=0 → MispredictE=1, next PCF=0x40, MispredCount=1. Fetching 0x10 again then gives PredTakenF=1, PredTargetF=0x40, ctr=10.
- Resolve 0x10 taken twice more, then not taken four times → ctr goes 11,11,10,01,00,00; PredTakenF for 0x10 is 0 once ctr ≤ 01; the first not-taken resolution (PredTakenE=1) mispredicts with redirect 0x14.
- jalr: PCSrcE=10, ALUResultE=0x1235, PredTakenE=1, PredTargetE=0x1230 → actTarget=0x1234, MispredictE=1, PCF=0x1234, BTB target updated to 0x1234.
- StallF=1 together with MispredictE=1 (redirect 0x80) → PCF=0x80 next cycle. StallF=1 alone → PCF is held for 3 cycles.
- Alias: train 0x10 taken, then resolve 0x50 (same index when IDX_BITS=4) taken to 0x90 → the entry is overwritten; fetch at 0x10 misses with PredTakenF=0. Asserting rst mid-run → PCF=0 immediately, all lookups miss, MispredCount=0.
